// File: rtl/spi_memory_burst_if.sv
// Pin-level bundle between the SPI pads and spi_memory_burst.
// master drives the SPI pins (pads/bench); slave is the memory block.
interface spi_memory_burst_if #(
  parameter int ADDR_W = 7
) ();
  logic              sclk_pin;
  logic              cs_pin;
  logic              mosi_pin;
  logic              miso_pin;
  logic              miso_oe;
  logic              busy;
  logic [ADDR_W-1:0] last_addr;

  modport master (
    output sclk_pin, cs_pin, mosi_pin,
    input  miso_pin, miso_oe, busy, last_addr
  );

  modport slave (
    input  sclk_pin, cs_pin, mosi_pin,
    output miso_pin, miso_oe, busy, last_addr
  );
endinterface

// File: rtl/spi_memory_burst.sv
// Mode-0 SPI slave register file with glitch-filtered pins and {addr,rw} header.
// Define SPIMEM_BURST_EN for auto-incrementing (wrapping) burst transfers.
module spi_memory_burst #(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 8,
  parameter int FILTER_CYC = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_memory_burst_if.slave spi
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int HDR_W = ADDR_W + 1;
  localparam int SH_W  = (HDR_W > DATA_W) ? HDR_W : DATA_W;
  localparam int CNT_W = $clog2(SH_W + 1);

  localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [3:0]       FILT_LAST = 4'(FILTER_CYC - 1);

  localparam int P_CS   = 0;
  localparam int P_SCLK = 1;
  localparam int P_MOSI = 2;
  localparam logic [2:0] PIN_RST = 3'b001;

`ifdef SPIMEM_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_HDR       = 3'd1,
    S_WR_DATA   = 3'd2,
    S_WR_COMMIT = 3'd3,
    S_RD_LOAD   = 3'd4,
    S_RD_SHIFT  = 3'd5,
    S_HOLD      = 3'd6
  } state_e;

  // ---------------- pin conditioner ----------------
  logic [2:0]      pins_s;
  logic [2:0]      sync1_q, sync2_q;
  logic [2:0]      level_q, level_d;
  logic [2:0][3:0] filt_q, filt_d;
  logic [1:0]      rise_q, fall_q;
  logic            busy_q;

  assign pins_s = {spi.mosi_pin, spi.sclk_pin, spi.cs_pin};

  // A level change is accepted only after FILTER_CYC consecutive differing samples.
  always_comb begin
    level_d = level_q;
    filt_d  = '0;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] != level_q[i]) begin
        if (filt_q[i] == FILT_LAST) begin
          level_d[i] = sync2_q[i];
        end else begin
          filt_d[i] = filt_q[i] + 4'd1;
        end
      end else begin
        filt_d[i] = 4'd0;
      end
    end
  end

  // Synchroniser, filter state and edge pulses for CS and SCLK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= PIN_RST;
      sync2_q <= PIN_RST;
      level_q <= PIN_RST;
      filt_q  <= '0;
      rise_q  <= 2'b00;
      fall_q  <= 2'b00;
      busy_q  <= 1'b0;
    end else begin
      sync1_q <= pins_s;
      sync2_q <= sync1_q;
      level_q <= level_d;
      filt_q  <= filt_d;
      rise_q  <= level_d[1:0] & ~level_q[1:0];
      fall_q  <= ~level_d[1:0] & level_q[1:0];
      busy_q  <= ~level_d[P_CS];
    end
  end

  logic cs_rise_s, cs_fall_s, sclk_rise_s, sclk_fall_s, mosi_s;
  assign cs_rise_s   = rise_q[P_CS];
  assign cs_fall_s   = fall_q[P_CS];
  assign sclk_rise_s = rise_q[P_SCLK];
  assign sclk_fall_s = fall_q[P_SCLK];
  assign mosi_s      = level_q[P_MOSI];

  // ---------------- frame FSM ----------------
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [SH_W-1:0]   shift_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] last_addr_q;
  logic              miso_q;
  logic              miso_oe_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; a CS rise aborts from anywhere, discarding any partial word.
  always_comb begin
    state_d = state_q;
    if (cs_rise_s) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cs_fall_s) state_d = S_HDR;
          else           state_d = S_IDLE;
        end
        S_HDR: begin
          if (sclk_rise_s && (bit_cnt_q == HDR_LAST)) begin
            if (mosi_s) state_d = S_RD_LOAD;
            else        state_d = S_WR_DATA;
          end else begin
            state_d = S_HDR;
          end
        end
        S_WR_DATA: begin
          if (sclk_rise_s && (bit_cnt_q == DATA_LAST)) state_d = S_WR_COMMIT;
          else                                         state_d = S_WR_DATA;
        end
        S_WR_COMMIT: begin
          if (BURST) state_d = S_WR_DATA;
          else       state_d = S_HOLD;
        end
        S_RD_LOAD: begin
          state_d = S_RD_SHIFT;
        end
        S_RD_SHIFT: begin
          // The word ends on the master's sampling edge of its last bit.
          if (sclk_rise_s && (bit_cnt_q == DATA_LAST)) begin
            if (BURST) state_d = S_RD_LOAD;
            else       state_d = S_HOLD;
          end else begin
            state_d = S_RD_SHIFT;
          end
        end
        S_HOLD: begin
          state_d = S_HOLD;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  logic clr_s, hdr_shift_s, addr_latch_s, wr_shift_s, commit_s, load_s, drive_s, rd_count_s;

  // Per-state datapath strobes.
  always_comb begin
    clr_s        = 1'b0;
    hdr_shift_s  = 1'b0;
    addr_latch_s = 1'b0;
    wr_shift_s   = 1'b0;
    commit_s     = 1'b0;
    load_s       = 1'b0;
    drive_s      = 1'b0;
    rd_count_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        clr_s = cs_fall_s;
      end
      S_HDR: begin
        hdr_shift_s  = sclk_rise_s;
        addr_latch_s = sclk_rise_s && (bit_cnt_q == HDR_LAST);
      end
      S_WR_DATA: begin
        wr_shift_s = sclk_rise_s;
      end
      S_WR_COMMIT: begin
        commit_s = ~cs_rise_s;
      end
      S_RD_LOAD: begin
        load_s = ~cs_rise_s;
      end
      S_RD_SHIFT: begin
        drive_s    = sclk_fall_s;
        rd_count_s = sclk_rise_s;
      end
      S_HOLD: begin
        clr_s = 1'b0;
      end
      default: begin
        clr_s = 1'b0;
      end
    endcase
  end

  // Bit counter, shift register, address and registered pin outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      addr_q      <= '0;
      last_addr_q <= '0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
    end else begin
      miso_oe_q <= (state_d == S_RD_LOAD) || (state_d == S_RD_SHIFT);
      if (clr_s) begin
        bit_cnt_q <= '0;
        shift_q   <= '0;
      end else if (hdr_shift_s) begin
        // The rw bit arrives last, so the address is already in the low bits.
        shift_q <= {shift_q[SH_W-2:0], mosi_s};
        if (addr_latch_s) begin
          addr_q    <= shift_q[ADDR_W-1:0];
          bit_cnt_q <= '0;
        end else begin
          bit_cnt_q <= bit_cnt_q + CNT_W'(1);
        end
      end else if (wr_shift_s) begin
        shift_q   <= {shift_q[SH_W-2:0], mosi_s};
        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
      end else if (commit_s) begin
        last_addr_q <= addr_q;
        bit_cnt_q   <= '0;
        if (BURST) addr_q <= addr_q + ADDR_W'(1);
      end else if (load_s) begin
        shift_q[DATA_W-1:0] <= mem_q[addr_q];
        last_addr_q         <= addr_q;
        bit_cnt_q           <= '0;
      end else if (drive_s) begin
        miso_q  <= shift_q[DATA_W-1];
        shift_q <= shift_q << 1;
      end else if (rd_count_s) begin
        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
        if (BURST && (bit_cnt_q == DATA_LAST)) addr_q <= addr_q + ADDR_W'(1);
      end
    end
  end

  // Storage array; deliberately not reset.
  always_ff @(posedge clk) begin
    if (commit_s) begin
      mem_q[addr_q] <= shift_q[DATA_W-1:0];
    end
  end

  assign spi.miso_pin  = miso_q;
  assign spi.miso_oe   = miso_oe_q;
  assign spi.busy      = busy_q;
  assign spi.last_addr = last_addr_q;

endmodule

// File: tb/tb_spi_memory_burst.sv
// Randomised bench for spi_memory_burst: a word-level memory model feeds an
// expectation queue that a MISO monitor drains independently of the stimulus.
module tb_spi_memory_burst;
  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 8;
  localparam int FILTER_CYC = 3;
  localparam int DEPTH      = 2 ** ADDR_W;
  localparam int HALF       = FILTER_CYC + 9;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_memory_burst_if #(.ADDR_W(ADDR_W)) spi ();

  spi_memory_burst #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FILTER_CYC(FILTER_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .spi(spi)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [DATA_W-1:0] model_mem [DEPTH];
  int                written [$];
  logic [DATA_W-1:0] exp_q [$];
  logic [ADDR_W-1:0] exp_last;
  logic [DATA_W-1:0] wbuf [4];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One mode-0 bit; optionally a 1-clk SCLK glitch in the low phase.
  task automatic clock_bit(input logic b, input bit glitch);
    spi.mosi_pin = b;
    if (glitch) begin
      tick(4);
      spi.sclk_pin = 1'b1;
      tick(1);
      spi.sclk_pin = 1'b0;
      tick(HALF - 5);
    end else begin
      tick(HALF);
    end
    spi.sclk_pin = 1'b1;
    tick(HALF);
    spi.sclk_pin = 1'b0;
  endtask

  task automatic send_header(input logic [ADDR_W-1:0] a, input logic rw, input int glitch_at);
    spi.cs_pin = 1'b0;
    tick(HALF);
    for (int i = 0; i < ADDR_W; i++) clock_bit(a[ADDR_W-1-i], i == glitch_at);
    clock_bit(rw, 1'b0);
  endtask

  task automatic end_frame();
    tick(HALF);
    spi.cs_pin = 1'b1;
    tick(2 * HALF);
  endtask

  task automatic write_frame(input logic [ADDR_W-1:0] a, input int n, input int glitch_at);
    send_header(a, 1'b0, glitch_at);
    for (int k = 0; k < n; k++)
      for (int i = DATA_W - 1; i >= 0; i--) clock_bit(wbuf[k][i], 1'b0);
    end_frame();
`ifdef SPIMEM_BURST_EN
    for (int k = 0; k < n; k++) begin
      model_mem[(int'(a) + k) % DEPTH] = wbuf[k];
      written.push_back((int'(a) + k) % DEPTH);
    end
    exp_last = ADDR_W'((int'(a) + n - 1) % DEPTH);
`else
    model_mem[a] = wbuf[0];
    written.push_back(int'(a));
    exp_last = a;
`endif
    check("last_addr_wr", 32'(spi.last_addr), 32'(exp_last));
  endtask

  task automatic read_frame(input logic [ADDR_W-1:0] a, input int n, input int glitch_at);
`ifdef SPIMEM_BURST_EN
    for (int k = 0; k < n; k++) exp_q.push_back(model_mem[(int'(a) + k) % DEPTH]);
    exp_last = ADDR_W'((int'(a) + n) % DEPTH);
`else
    exp_q.push_back(model_mem[a]);
    exp_last = a;
`endif
    send_header(a, 1'b1, glitch_at);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < DATA_W; i++) begin
        spi.mosi_pin = 1'($urandom_range(0, 1));
        tick(HALF);
`ifndef SPIMEM_BURST_EN
        if (k > 0) check("oe_after_word", 32'(spi.miso_oe), 32'd0);
`endif
        spi.sclk_pin = 1'b1;
        tick(HALF);
        spi.sclk_pin = 1'b0;
      end
    end
    end_frame();
    check("last_addr_rd", 32'(spi.last_addr), 32'(exp_last));
  endtask

  task automatic check_reset_outputs();
    check("rst_miso", 32'(spi.miso_pin), 32'd0);
    check("rst_oe", 32'(spi.miso_oe), 32'd0);
    check("rst_busy", 32'(spi.busy), 32'd0);
    check("rst_last_addr", 32'(spi.last_addr), 32'd0);
  endtask

  // Monitor: assemble MISO bits on every master sampling edge while enabled.
  initial begin : monitor
    logic [DATA_W-1:0] got;
    logic [DATA_W-1:0] exp;
    int nb;
    nb = 0;
    got = '0;
    forever begin
      @(posedge spi.sclk_pin or posedge spi.cs_pin or negedge rst_n);
      if (spi.cs_pin || !rst_n) begin
        nb = 0;
      end else if (spi.miso_oe) begin
        got = {got[DATA_W-2:0], spi.miso_pin};
        nb++;
        if (nb == DATA_W) begin
          nb = 0;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_word: got 0x%0h expected none", got);
          end else begin
            exp = exp_q.pop_front();
            check("miso_word", 32'(got), 32'(exp));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [ADDR_W-1:0] a;
    int n;
    spi.cs_pin   = 1'b1;
    spi.sclk_pin = 1'b0;
    spi.mosi_pin = 1'b0;
    rst_n        = 1'b0;
    tick(5);
    check_reset_outputs();
    rst_n = 1'b1;
    tick(10);

    // Basic write then read at address 1.
    wbuf[0] = 8'h55;
    write_frame(7'd1, 1, -1);
    read_frame(7'd1, 1, -1);

    // Three words from the top address (wraps under burst; extras ignored otherwise).
    wbuf[0] = 8'hA1; wbuf[1] = 8'hB2; wbuf[2] = 8'hC3;
    write_frame(7'h7F, 3, -1);
    read_frame(7'h7F, 3, -1);
    read_frame(7'd1, 1, -1);

    // Aborted write: half a word then CS rises; check busy latency on the way.
    wbuf[0] = 8'h3C;
    write_frame(7'd5, 1, -1);
    send_header(7'd5, 1'b0, -1);
    for (int i = 0; i < 4; i++) clock_bit(1'(i % 2), 1'b0);
    tick(HALF);
    check("busy_in_frame", 32'(spi.busy), 32'd1);
    spi.cs_pin = 1'b1;
    tick(2 + FILTER_CYC - 1);
    check("busy_before_latency", 32'(spi.busy), 32'd1);
    tick(1);
    check("busy_after_latency", 32'(spi.busy), 32'd0);
    tick(2 * HALF);
    read_frame(7'd5, 1, -1);

    // SCLK glitches inside headers must not shift a bit.
    wbuf[0] = 8'h96;
    write_frame(7'h2A, 1, 2);
    read_frame(7'h2A, 1, 4);

    // Asynchronous reset in the middle of a data phase.
    send_header(7'h2A, 1'b0, -1);
    for (int i = 0; i < 3; i++) clock_bit(1'b1, 1'b0);
    tick(2);
    check("busy_pre_reset", 32'(spi.busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    spi.cs_pin = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(2 * HALF);
    read_frame(7'h2A, 1, -1);

    // Randomised traffic against the model.
    for (int r = 0; r < 8; r++) begin
      a = ADDR_W'($urandom_range(0, DEPTH - 1));
      n = $urandom_range(1, 2);
      wbuf[0] = DATA_W'($urandom);
      wbuf[1] = DATA_W'($urandom);
      write_frame(a, n, -1);
      a = ADDR_W'(written[$urandom_range(0, written.size() - 1)]);
      read_frame(a, 1, -1);
    end

    tick(20);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
